// File: rtl/candy_board_mem.sv
// candy_board_mem
// Board storage and responder for the Candy Crush game FSM.
// Holds an 8x8 grid of 3-bit candy colors (1..NUM_COLORS, 0 = empty).
// After reset or an InitBoard pulse, the whole board is refilled with
// random colors. The refill never creates a horizontal or vertical run
// of three equal colors.
//
// Ports:
//   Clk                  system clock, rising edge
//   Reset                asynchronous active-low reset
//   Enable               write enable for swap/refill (READY only)
//   InitBoard            single-cycle pulse in READY, restarts the fill
//   X, Y                 cursor coordinate, cell index = 8*Y+X
//   ColorXY              registered color of cell (X,Y), 1-cycle latency
//   swapFlag             swap (X,Y) with (swapX,swapY) this cycle
//   swapX, swapY         swap partner coordinate
//   randFlag             write a random color to (rewriteX,rewriteY)
//   rewriteX, rewriteY   refill coordinate
//   DispX, DispY         display read coordinate
//   DispColor            registered color of cell (DispX,DispY)
//   BoardReady           high only while in READY
module candy_board_mem #(
  parameter int          NUM_COLORS = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       InitBoard,
  input  logic [2:0] X,
  input  logic [2:0] Y,
  output logic [2:0] ColorXY,
  input  logic       swapFlag,
  input  logic [2:0] swapX,
  input  logic [2:0] swapY,
  input  logic       randFlag,
  input  logic [2:0] rewriteX,
  input  logic [2:0] rewriteY,
  input  logic [2:0] DispX,
  input  logic [2:0] DispY,
  output logic [2:0] DispColor,
  output logic       BoardReady
);

  typedef enum logic {FILL, READY} state_t;

  localparam logic [2:0]  NC       = 3'(NUM_COLORS);
  localparam logic [15:0] LFSR_TAP = 16'hB400;

  logic [2:0]  board [64];
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [5:0]  fill_idx;
  state_t      state;

  // Galois LFSR, x^16+x^14+x^13+x^11, right-shifting
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ LFSR_TAP;
  end

  // Fold the raw 3-bit value into 0..NUM_COLORS-1 (single subtraction)
  // and shift it to a legal color
  logic [2:0] raw;
  logic [2:0] c0;
  always_comb begin
    raw = lfsr[2:0];
    if (raw >= NC) raw = raw - NC;
    c0 = raw + 3'd1;
  end

  function automatic logic [2:0] wrap_inc(input logic [2:0] c);
    return (c >= NC) ? 3'd1 : c + 3'd1;
  endfunction

  // Fill color selection. Cells above and to the left are already
  // written, so the neighbour lookup reads the live board.
  logic [2:0] fx, fy;
  logic [2:0] fx_m1, fx_m2, fy_m1, fy_m2;
  logic [2:0] left1, left2, up1, up2;
  logic       ban_h, ban_v;
  logic [2:0] cand1, cand2;
  logic [2:0] fill_color;

  always_comb begin
    fx    = fill_idx[2:0];
    fy    = fill_idx[5:3];
    fx_m1 = fx - 3'd1;
    fx_m2 = fx - 3'd2;
    fy_m1 = fy - 3'd1;
    fy_m2 = fy - 3'd2;
    left1 = board[{fy, fx_m1}];
    left2 = board[{fy, fx_m2}];
    up1   = board[{fy_m1, fx}];
    up2   = board[{fy_m2, fx}];
    ban_h = (fx >= 3'd2) && (left1 == left2);
    ban_v = (fy >= 3'd2) && (up1 == up2);
    cand1 = wrap_inc(c0);
    cand2 = wrap_inc(cand1);
    // At most two colors are banned, so one of three consecutive
    // candidates is always legal.
    if (!(ban_h && c0 == left1) && !(ban_v && c0 == up1))
      fill_color = c0;
    else if (!(ban_h && cand1 == left1) && !(ban_v && cand1 == up1))
      fill_color = cand1;
    else
      fill_color = cand2;
  end

  logic [5:0] xy_idx, disp_idx, swap_a, swap_b, rw_idx;
  always_comb begin
    xy_idx   = {Y, X};
    disp_idx = {DispY, DispX};
    swap_a   = {Y, X};
    swap_b   = {swapY, swapX};
    rw_idx   = {rewriteY, rewriteX};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 64; i++) board[6'(i)] <= '0;
      ColorXY    <= '0;
      DispColor  <= '0;
      BoardReady <= 1'b0;
      lfsr       <= LFSR_SEED;
      fill_idx   <= '0;
      state      <= FILL;
    end else begin
      lfsr      <= lfsr_next;
      ColorXY   <= board[xy_idx];
      DispColor <= board[disp_idx];
      case (state)
        FILL: begin
          board[fill_idx] <= fill_color;
          if (fill_idx == 6'd63) begin
            fill_idx   <= '0;
            state      <= READY;
            BoardReady <= 1'b1;
          end else begin
            fill_idx <= fill_idx + 6'd1;
          end
        end
        READY: begin
          if (Enable && swapFlag) begin
            board[swap_a] <= board[swap_b];
            board[swap_b] <= board[swap_a];
          end
          // Placed after the swap so a coinciding refill target wins
          if (Enable && randFlag) board[rw_idx] <= c0;
          if (InitBoard) begin
            state      <= FILL;
            fill_idx   <= '0;
            BoardReady <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
